// File: rtl/ahf4722_risc521.sv
// RISC521 core: 8-bit single-cycle CPU with combinational program ROM, 4x8 register
// file, 16x8 data RAM, 5-bit switch input and a registered 8-bit display latch.
module ahf4722_risc521 #(
  parameter int PC_W   = 5,
  parameter int RAM_AW = 4,
  // Word k of the ROM occupies bits [16k+15:16k].
  parameter logic [(2**PC_W)*16-1:0] ROM_IMAGE = {
    {26{16'h0000}},
    16'hC002, 16'h9000, 16'h2100, 16'h8800, 16'h1401, 16'h1000
  }
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] SW_in,
  output logic [7:0] Disp_out
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t            r_state, w_state_nxt;
  logic [PC_W-1:0]   r_pc, w_pc_nxt;
  logic [7:0]        r_rf  [4];
  logic [7:0]        r_ram [2**RAM_AW];
  logic              r_z, r_c;
  logic [7:0]        r_disp;

  logic [15:0]       w_instr;
  logic [3:0]        w_op;
  logic [1:0]        w_rd, w_rs;
  logic [7:0]        w_imm, w_a, w_b;
  logic [8:0]        w_sum;
  logic [7:0]        w_res, w_wdata;
  logic              w_c_nxt, w_rf_we, w_flag_we, w_ram_we, w_disp_we;
  logic [RAM_AW-1:0] w_addr;

  assign w_instr  = ROM_IMAGE[{r_pc, 4'b0000} +: 16];
  assign w_op     = w_instr[15:12];
  assign w_rd     = w_instr[11:10];
  assign w_rs     = w_instr[9:8];
  assign w_imm    = w_instr[7:0];
  assign w_a      = r_rf[w_rd];
  assign w_b      = r_rf[w_rs];
  assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
  assign w_addr   = w_imm[RAM_AW-1:0];
  assign Disp_out = r_disp;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc + 1'b1;
    w_rf_we     = 1'b0;
    w_wdata     = '0;
    w_flag_we   = 1'b0;
    w_res       = '0;
    w_c_nxt     = r_c;
    w_ram_we    = 1'b0;
    w_disp_we   = 1'b0;
    if (r_state == ST_HALT) begin
      w_pc_nxt = r_pc;
    end else begin
      case (w_op)
        4'h1: begin w_rf_we = 1'b1; w_wdata = w_imm; end
        4'h2: begin w_flag_we = 1'b1; w_res = w_sum[7:0]; w_c_nxt = w_sum[8]; end
        4'h3: begin w_flag_we = 1'b1; w_res = w_a - w_b; w_c_nxt = (w_b > w_a); end
        4'h4: begin w_flag_we = 1'b1; w_res = w_a & w_b; w_c_nxt = 1'b0; end
        4'h5: begin w_flag_we = 1'b1; w_res = w_a | w_b; w_c_nxt = 1'b0; end
        4'h6: begin w_flag_we = 1'b1; w_res = w_a ^ w_b; w_c_nxt = 1'b0; end
        4'h7: begin
          w_flag_we = 1'b1;
          if (w_imm[0]) begin w_res = {1'b0, w_a[7:1]}; w_c_nxt = w_a[0]; end
          else          begin w_res = {w_a[6:0], 1'b0}; w_c_nxt = w_a[7]; end
        end
        4'h8: begin w_rf_we = 1'b1; w_wdata = {3'b000, SW_in}; end
        4'h9: w_disp_we = 1'b1;
        4'hA: begin w_rf_we = 1'b1; w_wdata = r_ram[w_addr]; end
        4'hB: w_ram_we = 1'b1;
        4'hC: w_pc_nxt = w_imm[PC_W-1:0];
        4'hD: if (r_z) w_pc_nxt = w_imm[PC_W-1:0];
        4'hE: if (r_c) w_pc_nxt = w_imm[PC_W-1:0];
        4'hF: begin w_state_nxt = ST_HALT; w_pc_nxt = r_pc; end
        default: ;
      endcase
      if (w_flag_we) begin
        w_rf_we = 1'b1;
        w_wdata = w_res;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_pc   <= '0;
      r_z    <= 1'b0;
      r_c    <= 1'b0;
      r_disp <= '0;
      for (int unsigned i = 0; i < 4; i++) r_rf[i] <= '0;
      for (int unsigned i = 0; i < 2**RAM_AW; i++) r_ram[i] <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      if (w_rf_we)   r_rf[w_rd]    <= w_wdata;
      if (w_ram_we)  r_ram[w_addr] <= w_b;
      if (w_disp_we) r_disp        <= w_b;
      if (w_flag_we) begin
        r_z <= (w_res == 8'h00);
        r_c <= w_c_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ahf4722_risc521.sv
// Bench for the RISC521 core: directed runs of the default and a halt program, plus a
// random-switch/random-reset run checked against an instruction-level reference model.
module tb_ahf4722_risc521;

  localparam logic [511:0] HALT_ROM = {
    {18{16'h0000}},
    16'hF000, 16'h9000, 16'hF000, 16'hE00C, 16'h3100, 16'h9100, 16'hE009,
    16'h9000, 16'hF000, 16'h9100, 16'hD006, 16'h2100, 16'h1401, 16'h10FF
  };

  localparam logic [511:0] ALU_ROM = {
    {3{16'h0000}},
    16'h9000, 16'hA005, 16'hF000, 16'hD01B, 16'h3F00, 16'h7800, 16'h9200,
    16'h2A00, 16'h1881, 16'h2A00, 16'h9300, 16'hD013, 16'h5D00, 16'h4C00,
    16'h9300, 16'hAC03, 16'hB103, 16'h7401, 16'h7400, 16'hE00B, 16'h9100,
    16'h3400, 16'h9000, 16'h6100, 16'hE007, 16'h9000, 16'h2100, 16'h8400,
    16'h8000
  };

  logic       Clk;
  logic       rst_def, rst_halt, rst_alu;
  logic [4:0] sw_def, sw_halt, sw_alu;
  logic [7:0] disp_def, disp_halt, disp_alu;

  int n_cmp = 0;
  int n_err = 0;

  ahf4722_risc521 u_def (
    .Clk(Clk), .Reset(rst_def), .SW_in(sw_def), .Disp_out(disp_def)
  );
  ahf4722_risc521 #(.ROM_IMAGE(HALT_ROM)) u_halt (
    .Clk(Clk), .Reset(rst_halt), .SW_in(sw_halt), .Disp_out(disp_halt)
  );
  ahf4722_risc521 #(.ROM_IMAGE(ALU_ROM)) u_alu (
    .Clk(Clk), .Reset(rst_alu), .SW_in(sw_alu), .Disp_out(disp_alu)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Default program: display shows n after edge 5+4(n-1), modulo 256.
  function automatic int def_disp(input int e);
    if (e < 5) return 0;
    return ((e - 5) / 4 + 1) % 256;
  endfunction

  // Instruction-set reference model for the ALU program.
  logic [511:0] m_rom;
  int m_rf [4];
  int m_ram [16];
  int m_pc, m_z, m_c, m_disp;
  bit m_halt;

  task automatic model_step(input bit rst, input int sw);
    int ins, op, rd, rs, imm, a, b, r, nxt;
    bit alu;
    if (rst) begin
      foreach (m_rf[i]) m_rf[i] = 0;
      foreach (m_ram[i]) m_ram[i] = 0;
      m_pc = 0; m_z = 0; m_c = 0; m_disp = 0; m_halt = 0;
      return;
    end
    if (m_halt) return;
    ins = int'(m_rom[m_pc*16 +: 16]);
    op  = ins / 4096;
    rd  = (ins / 1024) % 4;
    rs  = (ins / 256) % 4;
    imm = ins % 256;
    a   = m_rf[rd];
    b   = m_rf[rs];
    nxt = (m_pc + 1) % 32;
    alu = 0;
    r   = 0;
    case (op)
      1:  m_rf[rd] = imm;
      2:  begin r = a + b; m_c = (r > 255) ? 1 : 0; alu = 1; end
      3:  begin r = a - b + 256; m_c = (b > a) ? 1 : 0; alu = 1; end
      4:  begin r = a & b; m_c = 0; alu = 1; end
      5:  begin r = a | b; m_c = 0; alu = 1; end
      6:  begin r = a ^ b; m_c = 0; alu = 1; end
      7:  begin
            if (imm % 2 == 1) begin m_c = a % 2; r = a / 2; end
            else              begin m_c = a / 128; r = a * 2; end
            alu = 1;
          end
      8:  m_rf[rd] = sw;
      9:  m_disp = b;
      10: m_rf[rd] = m_ram[imm % 16];
      11: m_ram[imm % 16] = b;
      12: nxt = imm % 32;
      13: if (m_z == 1) nxt = imm % 32;
      14: if (m_c == 1) nxt = imm % 32;
      15: begin m_halt = 1; nxt = m_pc; end
      default: ;
    endcase
    if (alu) begin
      r = r % 256;
      m_rf[rd] = r;
      m_z = (r == 0) ? 1 : 0;
    end
    m_pc = nxt;
  endtask

  initial begin
    m_rom    = ALU_ROM;
    rst_def  = 1'b1; rst_halt = 1'b1; rst_alu = 1'b1;
    sw_def   = '0;   sw_halt  = '0;   sw_alu  = '0;

    // Default program: reset, count, IN tracking, mid-loop reset, 0xFF wrap.
    tick();
    check_eq("def_reset_disp", disp_def, 0);
    check_eq("def_reset_pc", u_def.r_pc, 0);
    rst_def = 1'b0;
    for (int e = 1; e <= 29; e++) begin
      sw_def = (e == 3) ? 5'b10101 : 5'($urandom);
      tick();
      check_eq($sformatf("def_disp_e%0d", e), disp_def, def_disp(e));
      if (e == 3) check_eq("def_in_r2_15", u_def.r_rf[2], 8'h15);
      if (e >= 3 && (e - 3) % 4 == 0) check_eq($sformatf("def_in_r2_e%0d", e), u_def.r_rf[2], sw_def);
    end
    check_eq("def_disp_before_reset", disp_def, 7);
    rst_def = 1'b1;
    tick();
    check_eq("def_midreset_disp", disp_def, 0);
    check_eq("def_midreset_pc", u_def.r_pc, 0);
    rst_def = 1'b0;
    for (int e = 1; e <= 1030; e++) begin
      sw_def = 5'($urandom);
      tick();
      check_eq($sformatf("def_disp2_e%0d", e), disp_def, def_disp(e));
    end

    // Halt program: carry/zero branch, SUB borrow, HALT freeze, reset release.
    tick();
    check_eq("halt_reset_disp", disp_halt, 0);
    rst_halt = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      check_eq($sformatf("halt_disp_e%0d", e), disp_halt, (e >= 9) ? 8'hFF : 8'h00);
      if (e == 3) begin
        check_eq("halt_add_r0", u_halt.r_rf[0], 0);
        check_eq("halt_add_z", u_halt.r_z, 1);
        check_eq("halt_add_c", u_halt.r_c, 1);
      end
      if (e == 4) check_eq("halt_jz_pc", u_halt.r_pc, 6);
      if (e == 5) check_eq("halt_out_pc", u_halt.r_pc, 7);
      if (e == 6) check_eq("halt_jc_pc", u_halt.r_pc, 9);
      if (e == 7) begin
        check_eq("halt_sub_r0", u_halt.r_rf[0], 8'hFF);
        check_eq("halt_sub_c", u_halt.r_c, 1);
      end
      if (e == 8) check_eq("halt_jc2_pc", u_halt.r_pc, 12);
      if (e >= 10) check_eq($sformatf("halt_frozen_pc_e%0d", e), u_halt.r_pc, 13);
    end
    rst_halt = 1'b1;
    tick();
    check_eq("halt_release_disp", disp_halt, 0);
    check_eq("halt_release_pc", u_halt.r_pc, 0);
    rst_halt = 1'b0;
    tick();
    check_eq("halt_restart_pc", u_halt.r_pc, 1);

    // ALU program under random switches and occasional reset, against the model.
    rst_alu = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge Clk);
      model_step(rst_alu, int'(sw_alu));
      #1;
      check_eq($sformatf("alu_disp_c%0d", cyc), disp_alu, m_disp);
      check_eq($sformatf("alu_pc_c%0d", cyc), u_alu.r_pc, m_pc);
      sw_alu  = 5'($urandom);
      rst_alu = ($urandom_range(0, 99) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
